// File: rtl/debug_page_capture_if.sv
// rtl/debug_page_capture_if.sv - debug bus, raw keys and page display signals
interface debug_page_capture_if;
   logic [127:0] debug_in;
   logic         key_page_n;
   logic         key_freeze_n;
   logic [31:0]  page_value;
   logic [1:0]   page_sel;
   logic         frozen;

   modport master (
      output debug_in, key_page_n, key_freeze_n,
      input  page_value, page_sel, frozen
   );

   modport slave (
      input  debug_in, key_page_n, key_freeze_n,
      output page_value, page_sel, frozen
   );
endinterface

// File: rtl/debug_page_capture.sv
// rtl/debug_page_capture.sv - debounced page/freeze capture of the 128-bit debug bus (option: DEBUG_PAGE_AUTOSCROLL_EN)
module debug_page_capture #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20,
   parameter int SCROLL_CYCLES   = 50000000
) (
   input  logic                 clk,
   input  logic                 reset,
   debug_page_capture_if.slave  bus
);
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       page_sync_q, freeze_sync_q;
   logic             page_stable_q, page_stable_d;
   logic             freeze_stable_q, freeze_stable_d;
   logic [CNT_W-1:0] page_cnt_q, page_cnt_d;
   logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;
   logic             page_evt_q, page_evt_d;
   logic             freeze_evt_q, freeze_evt_d;
   logic [1:0]       page_sel_q, page_sel_d;
   logic             frozen_q, frozen_d;
   logic [127:0]     capture_q, capture_d;
   logic             scroll_tick;

   // Two-flop synchronizers; idle level is released (1)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         page_sync_q   <= 2'b11;
         freeze_sync_q <= 2'b11;
      end else begin
         page_sync_q   <= {page_sync_q[0], bus.key_page_n};
         freeze_sync_q <= {freeze_sync_q[0], bus.key_freeze_n};
      end
   end

   // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing cycles; flag presses
   always_comb begin
      page_stable_d   = page_stable_q;
      page_cnt_d      = '0;
      page_evt_d      = 1'b0;
      freeze_stable_d = freeze_stable_q;
      freeze_cnt_d    = '0;
      freeze_evt_d    = 1'b0;
      if (page_sync_q[1] != page_stable_q) begin
         if (page_cnt_q == DB_LAST) begin
            page_stable_d = page_sync_q[1];
            page_evt_d    = ~page_sync_q[1];
         end else begin
            page_cnt_d = page_cnt_q + CNT_W'(1);
         end
      end
      if (freeze_sync_q[1] != freeze_stable_q) begin
         if (freeze_cnt_q == DB_LAST) begin
            freeze_stable_d = freeze_sync_q[1];
            freeze_evt_d    = ~freeze_sync_q[1];
         end else begin
            freeze_cnt_d = freeze_cnt_q + CNT_W'(1);
         end
      end
   end

`ifdef DEBUG_PAGE_AUTOSCROLL_EN
   localparam int              SC_W    = $clog2(SCROLL_CYCLES + 1);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCROLL_CYCLES - 1);
   logic [SC_W-1:0] scroll_cnt_q, scroll_cnt_d;

   // Auto-scroll timer runs only while frozen; a manual page press restarts it and takes priority
   always_comb begin
      scroll_cnt_d = '0;
      scroll_tick  = 1'b0;
      if (frozen_q && !page_evt_q) begin
         if (scroll_cnt_q == SC_LAST) begin
            scroll_tick = 1'b1;
         end else begin
            scroll_cnt_d = scroll_cnt_q + SC_W'(1);
         end
      end
   end

   // Auto-scroll timer register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scroll_cnt_q <= '0;
      end else begin
         scroll_cnt_q <= scroll_cnt_d;
      end
   end
`else
   assign scroll_tick = 1'b0;
`endif

   // Page stepping, freeze toggle, and capture that tracks the bus whenever not frozen
   always_comb begin
      page_sel_d = page_sel_q;
      if (page_evt_q || scroll_tick) begin
         page_sel_d = page_sel_q + 2'd1;
      end
      frozen_d  = frozen_q ^ freeze_evt_q;
      capture_d = frozen_q ? capture_q : bus.debug_in;
   end

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         page_stable_q   <= 1'b1;
         freeze_stable_q <= 1'b1;
         page_cnt_q      <= '0;
         freeze_cnt_q    <= '0;
         page_evt_q      <= 1'b0;
         freeze_evt_q    <= 1'b0;
         page_sel_q      <= 2'd0;
         frozen_q        <= 1'b0;
         capture_q       <= '0;
      end else begin
         page_stable_q   <= page_stable_d;
         freeze_stable_q <= freeze_stable_d;
         page_cnt_q      <= page_cnt_d;
         freeze_cnt_q    <= freeze_cnt_d;
         page_evt_q      <= page_evt_d;
         freeze_evt_q    <= freeze_evt_d;
         page_sel_q      <= page_sel_d;
         frozen_q        <= frozen_d;
         capture_q       <= capture_d;
      end
   end

   assign bus.page_value = capture_q[{page_sel_q, 5'd0} +: 32];
   assign bus.page_sel   = page_sel_q;
   assign bus.frozen     = frozen_q;
endmodule
